// File: rtl/sme_dispatch_sched_if.sv
// sme_dispatch_sched_if
//   Bundles the three streams around the SME dispatch scheduler:
//     s_req_*  : job request stream {class, addr, len, tag} (valid/ready)
//     desc_*   : read-DMA descriptor stream {accel_id, addr, len} (valid/ready)
//     m_res_*  : job result stream {tag, accel, match, vec, timeout} (valid/ready)
//   slave  modport : the scheduler side
//   master modport : the environment (core / DMA / result consumer) side
interface sme_dispatch_sched_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 14,
  parameter int TAG_WIDTH  = 8,
  parameter int DEST_WIDTH = 4
);
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [1:0]            s_req_class;
  logic [ADDR_WIDTH-1:0] s_req_addr;
  logic [LEN_WIDTH-1:0]  s_req_len;
  logic [TAG_WIDTH-1:0]  s_req_tag;

  logic                  desc_valid;
  logic                  desc_ready;
  logic [DEST_WIDTH-1:0] desc_accel_id;
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic [LEN_WIDTH-1:0]  desc_len;

  logic                  m_res_valid;
  logic                  m_res_ready;
  logic [TAG_WIDTH-1:0]  m_res_tag;
  logic [DEST_WIDTH-1:0] m_res_accel;
  logic                  m_res_match;
  logic [31:0]           m_res_vec;
  logic                  m_res_timeout;

  modport slave (
    input  s_req_valid, s_req_class, s_req_addr, s_req_len, s_req_tag,
    output s_req_ready,
    output desc_valid, desc_accel_id, desc_addr, desc_len,
    input  desc_ready,
    output m_res_valid, m_res_tag, m_res_accel, m_res_match, m_res_vec, m_res_timeout,
    input  m_res_ready
  );

  modport master (
    output s_req_valid, s_req_class, s_req_addr, s_req_len, s_req_tag,
    input  s_req_ready,
    input  desc_valid, desc_accel_id, desc_addr, desc_len,
    output desc_ready,
    input  m_res_valid, m_res_tag, m_res_accel, m_res_match, m_res_vec, m_res_timeout,
    output m_res_ready
  );
endinterface

// File: rtl/sme_dispatch_sched.sv
// sme_dispatch_sched
//   Schedules match jobs onto a pool of SME accelerators grouped by class
//   (TCP, UDP, HTTP, fixed-loc). A request takes the lowest free accelerator
//   of its class, which gets a one-cycle init pulse followed by a DMA
//   descriptor. Each running slot has a watchdog that pulses stop after
//   TIMEOUT run cycles. Finished slots are drained round-robin into a
//   single registered result stream.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : request / descriptor / result streams (slave side)
//   accel_init     : one-hot one-cycle init per accelerator
//   accel_stop     : one-hot one-cycle watchdog stop per accelerator
//   accel_done     : sticky done status per accelerator
//   accel_match    : sticky match status per accelerator
//   accel_vec      : sticky 32-bit match one-hot per accelerator
//   slot_busy      : per-accelerator occupancy (slot not FREE)
module sme_dispatch_sched #(
  parameter int TCP_COUNT   = 4,
  parameter int UDP_COUNT   = 4,
  parameter int HTTP_COUNT  = 4,
  parameter int FIXED_COUNT = 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 14,
  parameter int TAG_WIDTH   = 8,
  parameter int TIMEOUT     = 65535,
  localparam int ACCEL_COUNT = TCP_COUNT + UDP_COUNT + HTTP_COUNT + FIXED_COUNT,
  localparam int DEST_WIDTH  = $clog2(ACCEL_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sme_dispatch_sched_if.slave       bus,
  output logic [ACCEL_COUNT-1:0]    accel_init,
  output logic [ACCEL_COUNT-1:0]    accel_stop,
  input  logic [ACCEL_COUNT-1:0]    accel_done,
  input  logic [ACCEL_COUNT-1:0]    accel_match,
  input  logic [ACCEL_COUNT*32-1:0] accel_vec,
  output logic [ACCEL_COUNT-1:0]    slot_busy
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ALLOC, SLOT_RUN, SLOT_PEND} slot_state_e;
  typedef enum logic [1:0] {ISS_IDLE, ISS_INIT, ISS_DESC} iss_state_e;

  iss_state_e            iss_q, iss_d;
  logic [DEST_WIDTH-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  // Keeps s_req_ready low while in reset and for the first cycle after it.
  logic                  live_q, live_d;

  logic                  res_valid_q, res_valid_d;
  logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;
  logic [DEST_WIDTH-1:0] res_accel_q, res_accel_d;
  logic                  res_match_q, res_match_d;
  logic [31:0]           res_vec_q, res_vec_d;
  logic                  res_to_q, res_to_d;
  logic [DEST_WIDTH-1:0] rr_q, rr_d;

  logic [ACCEL_COUNT-1:0]           cls_free, pend_vec, to_vec;
  logic [ACCEL_COUNT*TAG_WIDTH-1:0] tag_flat;
  logic                  pick_ok, req_fire, desc_fire, res_fire;
  logic [DEST_WIDTH-1:0] pick_idx;

  // ---------------- per-slot state, watchdog and tag ----------------
  for (genvar gi = 0; gi < ACCEL_COUNT; gi++) begin : g_slot
    localparam logic [1:0] SLOT_CLS =
      (gi < TCP_COUNT)                          ? 2'd0 :
      (gi < TCP_COUNT + UDP_COUNT)              ? 2'd1 :
      (gi < TCP_COUNT + UDP_COUNT + HTTP_COUNT) ? 2'd2 : 2'd3;

    slot_state_e          state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 to_q, to_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 stop_w;

    always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      to_d    = to_q;
      tag_d   = tag_q;
      stop_w  = 1'b0;
      case (state_q)
        SLOT_FREE: if (req_fire && pick_idx == DEST_WIDTH'(gi)) begin
          state_d = SLOT_ALLOC;
          tag_d   = bus.s_req_tag;
          to_d    = 1'b0;
        end
        SLOT_ALLOC: if (desc_fire && sel_q == DEST_WIDTH'(gi)) begin
          state_d = SLOT_RUN;
          wd_d    = '0;
        end
        SLOT_RUN: begin
          // A done seen in the stop cycle wins: no stop, flag stays clear.
          if (accel_done[gi]) begin
            state_d = SLOT_PEND;
          end else if (TIMEOUT != 0 && !to_q && wd_q == WD_LAST) begin
            stop_w = 1'b1;
            to_d   = 1'b1;
          end else if (wd_q != WD_LAST) begin
            wd_d = wd_q + 1'b1;
          end
        end
        SLOT_PEND: if (res_fire && res_accel_q == DEST_WIDTH'(gi)) state_d = SLOT_FREE;
        default: state_d = SLOT_FREE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SLOT_FREE;
        wd_q    <= '0;
        to_q    <= 1'b0;
        tag_q   <= '0;
      end else begin
        state_q <= state_d;
        wd_q    <= wd_d;
        to_q    <= to_d;
        tag_q   <= tag_d;
      end
    end

    assign slot_busy[gi]  = (state_q != SLOT_FREE);
    assign pend_vec[gi]   = (state_q == SLOT_PEND);
    assign cls_free[gi]   = (state_q == SLOT_FREE) && (bus.s_req_class == SLOT_CLS);
    assign to_vec[gi]     = to_q;
    assign accel_stop[gi] = stop_w;
    assign tag_flat[gi*TAG_WIDTH +: TAG_WIDTH] = tag_q;
  end

  // ---------------- issue FSM ----------------
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    // Descending scan so the lowest free index is the one left selected.
    for (int i = ACCEL_COUNT - 1; i >= 0; i--) begin
      if (cls_free[i]) begin
        pick_ok  = 1'b1;
        pick_idx = DEST_WIDTH'(i);
      end
    end
  end

  assign bus.s_req_ready   = live_q && (iss_q == ISS_IDLE) && pick_ok;
  assign req_fire          = bus.s_req_valid && bus.s_req_ready;
  assign desc_fire         = (iss_q == ISS_DESC) && bus.desc_ready;
  assign bus.desc_valid    = (iss_q == ISS_DESC);
  assign bus.desc_accel_id = sel_q;
  assign bus.desc_addr     = addr_q;
  assign bus.desc_len      = len_q;
  assign accel_init        = (iss_q == ISS_INIT) ? (ACCEL_COUNT'(1) << sel_q) : '0;
  assign live_d            = 1'b1;

  always_comb begin
    iss_d  = iss_q;
    sel_d  = sel_q;
    addr_d = addr_q;
    len_d  = len_q;
    case (iss_q)
      ISS_IDLE: if (req_fire) begin
        iss_d  = ISS_INIT;
        sel_d  = pick_idx;
        addr_d = bus.s_req_addr;
        len_d  = bus.s_req_len;
      end
      ISS_INIT: iss_d = ISS_DESC;
      ISS_DESC: if (bus.desc_ready) iss_d = ISS_IDLE;
      default:  iss_d = ISS_IDLE;
    endcase
  end

  // ---------------- result path ----------------
  logic [ACCEL_COUNT-1:0] cand;
  logic                   lo_ok, hi_ok;
  logic [DEST_WIDTH-1:0]  lo_idx, hi_idx, grant_idx;

  assign res_fire = res_valid_q && bus.m_res_ready;
  // The slot whose result sits in the output register stays PEND until its
  // handshake, so it must be masked from arbitration.
  assign cand = pend_vec & ~(res_valid_q ? (ACCEL_COUNT'(1) << res_accel_q) : '0);

  always_comb begin
    lo_ok  = 1'b0;
    hi_ok  = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    // Lowest candidate at or above the pointer, else lowest overall.
    for (int i = ACCEL_COUNT - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_ok  = 1'b1;
        lo_idx = DEST_WIDTH'(i);
        if (i >= int'(rr_q)) begin
          hi_ok  = 1'b1;
          hi_idx = DEST_WIDTH'(i);
        end
      end
    end
    grant_idx = hi_ok ? hi_idx : lo_idx;
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_accel_d = res_accel_q;
    res_match_d = res_match_q;
    res_vec_d   = res_vec_q;
    res_to_d    = res_to_q;
    rr_d        = rr_q;
    if (!res_valid_q || bus.m_res_ready) begin
      res_valid_d = lo_ok;
      if (lo_ok) begin
        res_accel_d = grant_idx;
        rr_d        = (grant_idx == DEST_WIDTH'(ACCEL_COUNT - 1)) ? '0 : grant_idx + 1'b1;
        for (int i = 0; i < ACCEL_COUNT; i++) begin
          if (grant_idx == DEST_WIDTH'(i)) begin
            res_tag_d   = tag_flat[i*TAG_WIDTH +: TAG_WIDTH];
            res_match_d = accel_match[i];
            res_vec_d   = accel_vec[i*32 +: 32];
            res_to_d    = to_vec[i];
          end
        end
      end
    end
  end

  assign bus.m_res_valid   = res_valid_q;
  assign bus.m_res_tag     = res_tag_q;
  assign bus.m_res_accel   = res_accel_q;
  assign bus.m_res_match   = res_match_q;
  assign bus.m_res_vec     = res_vec_q;
  assign bus.m_res_timeout = res_to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q       <= ISS_IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      live_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_accel_q <= '0;
      res_match_q <= 1'b0;
      res_vec_q   <= '0;
      res_to_q    <= 1'b0;
      rr_q        <= '0;
    end else begin
      iss_q       <= iss_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      live_q      <= live_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_accel_q <= res_accel_d;
      res_match_q <= res_match_d;
      res_vec_q   <= res_vec_d;
      res_to_q    <= res_to_d;
      rr_q        <= rr_d;
    end
  end
endmodule

// File: tb/tb_sme_dispatch_sched.sv
// tb_sme_dispatch_sched
//   Directed bench for sme_dispatch_sched with TIMEOUT=16: reset values,
//   single job, class stall/release, HTTP match result, watchdog stop and
//   done-vs-stop race, round-robin drain under backpressure, reset mid-job.
module tb_sme_dispatch_sched;
  localparam int AC = 13;
  localparam int DW = 4;

  logic            clk;
  logic            rst_n;
  logic [AC-1:0]   accel_init, accel_stop, accel_done, accel_match, slot_busy;
  logic [AC*32-1:0] accel_vec;

  int errors = 0;
  int checks = 0;

  sme_dispatch_sched_if #(.ADDR_WIDTH(16), .LEN_WIDTH(14), .TAG_WIDTH(8), .DEST_WIDTH(DW)) bus ();

  sme_dispatch_sched #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .accel_init  (accel_init),
    .accel_stop  (accel_stop),
    .accel_done  (accel_done),
    .accel_match (accel_match),
    .accel_vec   (accel_vec),
    .slot_busy   (slot_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_req_valid = 1'b0;
    bus.s_req_class = 2'd0;
    bus.s_req_addr  = '0;
    bus.s_req_len   = '0;
    bus.s_req_tag   = '0;
    bus.desc_ready  = 1'b1;
    bus.m_res_ready = 1'b0;
    accel_done      = '0;
    accel_match     = '0;
    accel_vec       = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents a request, waits (bounded) for acceptance and returns the
  // accelerator id of its descriptor; leaves the slot in its first RUN cycle.
  task automatic issue(input logic [1:0] cls, input logic [15:0] addr, input logic [13:0] len,
                       input logic [7:0] tag, output int id);
    bit got = 0;
    id = -1;
    bus.s_req_class = cls;
    bus.s_req_addr  = addr;
    bus.s_req_len   = len;
    bus.s_req_tag   = tag;
    bus.s_req_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (bus.s_req_ready) begin
        got = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_ready: class %0d tag %h never accepted (ready=%b, required 1)", cls, tag, bus.s_req_ready);
      bus.s_req_valid = 1'b0;
      return;
    end
    tick();
    bus.s_req_valid = 1'b0;
    tick();
    id = int'(bus.desc_accel_id);
    tick();
    $display("issue: class %0d tag %h -> accel %0d", cls, tag, id);
  endtask

  task automatic wait_res(input string name);
    bit got = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.m_res_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_res_valid: got %b required 1 within 40 cycles", name, bus.m_res_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({bus.s_req_ready, bus.desc_valid, bus.m_res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: got %b required 000", {bus.s_req_ready, bus.desc_valid, bus.m_res_valid});
    end
    checks++;
    if ({accel_init, accel_stop, slot_busy} !== '0) begin
      errors++;
      $display("FAIL reset_vectors: init %h stop %h busy %h required 0", accel_init, accel_stop, slot_busy);
    end
    rst_n = 1'b1;
    tick();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit got = 0;
    do_reset();
    bus.s_req_class = 2'd0;
    bus.s_req_addr  = 16'h0100;
    bus.s_req_len   = 14'd64;
    bus.s_req_tag   = 8'h11;
    bus.s_req_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (bus.s_req_ready) begin
        got = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_ready: got %b required 1", bus.s_req_ready);
    end
    tick();
    bus.s_req_valid = 1'b0;
    checks++;
    if (accel_init !== 13'h0001) begin
      errors++;
      $display("FAIL single_init: got %h required 0001", accel_init);
    end
    tick();
    checks++;
    if ({bus.desc_valid, bus.desc_accel_id, bus.desc_addr, bus.desc_len} !== {1'b1, 4'd0, 16'h0100, 14'd64}) begin
      errors++;
      $display("FAIL single_desc: valid %b id %0d addr %h len %0d required 1 0 0100 64",
               bus.desc_valid, bus.desc_accel_id, bus.desc_addr, bus.desc_len);
    end
    tick();
    checks++;
    if ({bus.desc_valid, slot_busy} !== {1'b0, 13'h0001}) begin
      errors++;
      $display("FAIL single_run: desc_valid %b busy %h required 0 0001", bus.desc_valid, slot_busy);
    end
    accel_done[0] = 1'b1;
    wait_res("single");
    checks++;
    if ({bus.m_res_tag, bus.m_res_accel, bus.m_res_timeout, bus.m_res_match} !== {8'h11, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_result: tag %h accel %0d to %b match %b required 11 0 0 0",
               bus.m_res_tag, bus.m_res_accel, bus.m_res_timeout, bus.m_res_match);
    end
    bus.m_res_ready = 1'b1;
    tick();
    bus.m_res_ready = 1'b0;
    accel_done = '0;
    checks++;
    if ({bus.m_res_valid, slot_busy} !== {1'b0, 13'h0000}) begin
      errors++;
      $display("FAIL single_free: res_valid %b busy %h required 0 0000", bus.m_res_valid, slot_busy);
    end
    $display("test_single done");
  endtask

  task automatic test_stall();
    int id;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      issue(2'd0, 16'h0200 + 16'(n), 14'd32, 8'h20 + 8'(n), id);
      checks++;
      if (id != n) begin
        errors++;
        $display("FAIL stall_alloc%0d: accel %0d required %0d", n, id, n);
      end
    end
    checks++;
    if (slot_busy !== 13'h000F) begin
      errors++;
      $display("FAIL stall_busy: got %h required 000F", slot_busy);
    end
    bus.s_req_class = 2'd0;
    bus.s_req_tag   = 8'h24;
    bus.s_req_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (bus.s_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready%0d: got %b required 0", n, bus.s_req_ready);
      end
      tick();
    end
    accel_done[2] = 1'b1;
    wait_res("stall");
    checks++;
    if ({bus.m_res_accel, bus.m_res_tag} !== {4'd2, 8'h22}) begin
      errors++;
      $display("FAIL stall_result: accel %0d tag %h required 2 22", bus.m_res_accel, bus.m_res_tag);
    end
    bus.m_res_ready = 1'b1;
    tick();
    bus.m_res_ready = 1'b0;
    accel_done[2] = 1'b0;
    checks++;
    if (bus.s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: ready %b required 1", bus.s_req_ready);
    end
    tick();
    bus.s_req_valid = 1'b0;
    checks++;
    if (accel_init !== 13'h0004) begin
      errors++;
      $display("FAIL stall_reissue: init %h required 0004", accel_init);
    end
    tick();
    tick();
    $display("test_stall done");
  endtask

  task automatic test_http_match();
    int id;
    do_reset();
    issue(2'd2, 16'h0300, 14'd100, 8'h33, id);
    checks++;
    if (id != 8) begin
      errors++;
      $display("FAIL http_alloc: accel %0d required 8", id);
    end
    accel_match[8]        = 1'b1;
    accel_vec[8*32 +: 32] = 32'h0000_0020;
    accel_done[8]         = 1'b1;
    wait_res("http");
    checks++;
    if ({bus.m_res_match, bus.m_res_vec, bus.m_res_accel, bus.m_res_tag, bus.m_res_timeout} !==
        {1'b1, 32'h20, 4'd8, 8'h33, 1'b0}) begin
      errors++;
      $display("FAIL http_result: match %b vec %h accel %0d tag %h to %b required 1 00000020 8 33 0",
               bus.m_res_match, bus.m_res_vec, bus.m_res_accel, bus.m_res_tag, bus.m_res_timeout);
    end
    bus.m_res_ready = 1'b1;
    tick();
    bus.m_res_ready = 1'b0;
    idle_inputs();
    $display("test_http_match done");
  endtask

  task automatic test_watchdog();
    int id;
    logic [AC-1:0] early;
    do_reset();
    issue(2'd1, 16'h0400, 14'd16, 8'h44, id);
    checks++;
    if (id != 4) begin
      errors++;
      $display("FAIL wd_alloc: accel %0d required 4", id);
    end
    early = '0;
    for (int n = 1; n <= 15; n++) begin
      early = early | accel_stop;
      tick();
    end
    checks++;
    if (early !== '0) begin
      errors++;
      $display("FAIL wd_early_stop: got %h required 0000 in run cycles 1-15", early);
    end
    checks++;
    if (accel_stop !== 13'h0010) begin
      errors++;
      $display("FAIL wd_stop16: got %h required 0010", accel_stop);
    end
    tick();
    checks++;
    if (accel_stop !== '0) begin
      errors++;
      $display("FAIL wd_stop17: got %h required 0000", accel_stop);
    end
    accel_done[4] = 1'b1;
    wait_res("wd");
    checks++;
    if ({bus.m_res_timeout, bus.m_res_accel, bus.m_res_tag} !== {1'b1, 4'd4, 8'h44}) begin
      errors++;
      $display("FAIL wd_result: to %b accel %0d tag %h required 1 4 44",
               bus.m_res_timeout, bus.m_res_accel, bus.m_res_tag);
    end
    bus.m_res_ready = 1'b1;
    tick();
    bus.m_res_ready = 1'b0;
    accel_done[4] = 1'b0;
    // Done arriving in the very cycle the stop would fire.
    issue(2'd1, 16'h0410, 14'd16, 8'h45, id);
    repeat (15) tick();
    accel_done[4] = 1'b1;
    #1;
    checks++;
    if (accel_stop !== '0) begin
      errors++;
      $display("FAIL race_stop: got %h required 0000", accel_stop);
    end
    wait_res("race");
    checks++;
    if ({bus.m_res_timeout, bus.m_res_accel, bus.m_res_tag} !== {1'b0, 4'd4, 8'h45}) begin
      errors++;
      $display("FAIL race_result: to %b accel %0d tag %h required 0 4 45",
               bus.m_res_timeout, bus.m_res_accel, bus.m_res_tag);
    end
    bus.m_res_ready = 1'b1;
    tick();
    bus.m_res_ready = 1'b0;
    idle_inputs();
    $display("test_watchdog done");
  endtask

  task automatic test_round_robin();
    int id;
    int idx = 0;
    int exp_acc [3] = '{1, 5, 9};
    logic [7:0] exp_tag [3] = '{8'hA1, 8'hA5, 8'hA9};
    logic [1:0]  cls_list [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0]  tag_list [6] = '{8'hA0, 8'hA1, 8'hA4, 8'hA5, 8'hA8, 8'hA9};
    do_reset();
    for (int n = 0; n < 6; n++) issue(cls_list[n], 16'h0500, 14'd8, tag_list[n], id);
    for (int n = 0; n < 3; n++) accel_vec[exp_acc[n]*32 +: 32] = 32'h100 + 32'(exp_acc[n]);
    accel_done = 13'h0222;
    for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
      bus.m_res_ready = cyc[0];
      if (bus.m_res_valid) begin
        checks++;
        if ({bus.m_res_accel, bus.m_res_tag, bus.m_res_vec} !==
            {4'(exp_acc[idx]), exp_tag[idx], 32'h100 + 32'(exp_acc[idx])}) begin
          errors++;
          $display("FAIL rr_result%0d: accel %0d tag %h vec %h required %0d %h %h", idx,
                   bus.m_res_accel, bus.m_res_tag, bus.m_res_vec,
                   exp_acc[idx], exp_tag[idx], 32'h100 + 32'(exp_acc[idx]));
        end
        if (bus.m_res_ready) begin
          $display("rr: result %0d accel %0d tag %h", idx, bus.m_res_accel, bus.m_res_tag);
          idx++;
        end
      end
      tick();
    end
    bus.m_res_ready = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL rr_count: got %0d results required 3", idx);
    end
    idle_inputs();
    $display("test_round_robin done");
  endtask

  task automatic test_reset_mid();
    logic [AC-1:0] pulses;
    bit stray;
    do_reset();
    bus.desc_ready  = 1'b0;
    bus.s_req_class = 2'd0;
    bus.s_req_tag   = 8'h66;
    bus.s_req_valid = 1'b1;
    tick();
    bus.s_req_valid = 1'b0;
    tick();
    checks++;
    if (bus.desc_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_desc: desc_valid %b required 1", bus.desc_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.desc_valid, bus.s_req_ready, bus.m_res_valid, slot_busy, accel_init, accel_stop} !== '0) begin
      errors++;
      $display("FAIL mid_reset: desc %b ready %b res %b busy %h init %h stop %h required all 0",
               bus.desc_valid, bus.s_req_ready, bus.m_res_valid, slot_busy, accel_init, accel_stop);
    end
    tick();
    rst_n = 1'b1;
    pulses = '0;
    stray  = 0;
    for (int n = 0; n < 6; n++) begin
      pulses = pulses | accel_init | accel_stop;
      stray  = stray | bus.desc_valid;
      tick();
    end
    checks++;
    if ({stray, pulses} !== '0) begin
      errors++;
      $display("FAIL mid_release: desc %b init/stop %h required 0 0000", stray, pulses);
    end
    bus.desc_ready = 1'b1;
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_stall();
    test_http_match();
    test_watchdog();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
